wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter
// Register-file write-port arbiter with a scoreboard of pending registers.
// The primary source (in-order pipeline) always wins the write port and has
// no back-pressure. The secondary source (long-latency unit) is buffered in
// a small FIFO and drained whenever the primary source is idle. A busy bit
// per register is set when a long-latency op is issued and cleared when its
// result leaves the FIFO.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-low reset
//   p_valid      primary write request (always accepted)
//   p_addr       primary destination register
//   p_data       primary write data
//   s_valid      secondary write request
//   s_ready      secondary FIFO can accept this cycle
//   s_addr       secondary destination register
//   s_data       secondary write data
//   issue_valid  long-latency op issued this cycle
//   issue_addr   register to mark pending
//   busy         pending bit per register (registered)
//   wr_en        register-file write enable (registered)
//   wr_addr      register-file write address (registered)
//   wr_data      register-file write data (registered)

module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_valid,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [4:0]  s_addr,
  input  logic [31:0] s_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic [31:0] busy,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic          push;
  logic          pop;
  logic          sel_valid;
  logic [4:0]    sel_addr;
  logic [31:0]   sel_data;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic [31:0]   busy_next;

  // s_ready is based on the registered occupancy only, so a pop in the same
  // cycle never opens a slot for a full FIFO.
  assign s_ready   = rst & (count < DEPTH_C);
  assign push      = s_valid & s_ready;
  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // Primary always wins; the FIFO head is only consumed when the primary
  // source is idle, so the secondary source may starve.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = wr_addr;
    sel_data  = wr_data;
    pop       = 1'b0;
    if (p_valid) begin
      sel_valid = 1'b1;
      sel_addr  = p_addr;
      sel_data  = p_data;
    end else if (count != '0) begin
      sel_valid = 1'b1;
      sel_addr  = head_addr;
      sel_data  = head_data;
      pop       = 1'b1;
    end
  end

  // Clear for a retiring FIFO entry is applied first so that a same-cycle
  // issue to the same register wins. Register 0 is never pending.
  always_comb begin
    busy_next = busy;
    if (pop && (head_addr != 5'd0))
      busy_next[head_addr] = 1'b0;
    if (issue_valid && (issue_addr != 5'd0))
      busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // FIFO storage needs no reset: the pointers and count define validity.
  // push is already gated by rst through s_ready.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= s_addr;
      fifo_data[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two
  // depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port. A selected request to register 0 is consumed
  // but does not assert the write enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= 32'd0;
      busy    <= 32'd0;
    end else begin
      wr_en   <= sel_valid && (sel_addr != 5'd0);
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      busy    <= busy_next;
    end
  end

endmodule
